// File: rtl/cpu_prog_mem_if.sv
// Bus bundle between cpu_prog_mem and its neighbours: the CPU fetch/data port and the program-load stream.
// The master modport drives the CPU and loader requests; the slave modport is the memory stage.
interface cpu_prog_mem_if;
  logic [15:0] cpu_instr_addr;
  logic [15:0] cpu_data_addr;
  logic [15:0] cpu_result;
  logic        cpu_write;
  logic [15:0] cpu_instr;
  logic [15:0] cpu_data;
  logic        cpu_reset;
  logic        ld_start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_error;
  logic [15:0] ld_count;

  modport master (
    output cpu_instr_addr, cpu_data_addr, cpu_result, cpu_write,
    output ld_start, ld_valid, ld_data, ld_last,
    input  cpu_instr, cpu_data, cpu_reset, ld_ready, ld_error, ld_count
  );

  modport slave (
    input  cpu_instr_addr, cpu_data_addr, cpu_result, cpu_write,
    input  ld_start, ld_valid, ld_data, ld_last,
    output cpu_instr, cpu_data, cpu_reset, ld_ready, ld_error, ld_count
  );
endinterface

// File: rtl/cpu_prog_mem.sv
// Memory stage around the 16-bit CPU: combinational instr/data reads, registered data writes, program-load FSM.
// Optional macro DMEM_CLEAR_EN adds a CLR state that zeroes data memory before every load.
//
// state | meaning
// IDLE  | after reset, CPU held in reset, waiting for ld_start
// CLR   | (DMEM_CLEAR_EN only) zeroing dmem, one word per cycle
// LOAD  | streaming program words into imem, CPU held in reset
// CRST  | one final cycle of CPU reset so the PC clears
// RUN   | CPU released, data writes enabled
// ERR   | load overflowed imem, CPU held in reset until ld_start
module cpu_prog_mem #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic           clk,
  input  logic           reset,
  cpu_prog_mem_if.slave  bus
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [16:0] IDEPTH = 17'(IMEM_DEPTH);
  localparam logic [16:0] DDEPTH = 17'(DMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CRST,
    S_RUN,
    S_ERR
`ifdef DMEM_CLEAR_EN
    , S_CLR
`endif
  } state_t;

  state_t      r_state;
  logic        r_cpu_reset;
  logic        r_ld_ready;
  logic        r_ld_error;
  logic [16:0] r_ld_count;

  logic [15:0] r_imem [IMEM_DEPTH];
  logic [15:0] r_dmem [DMEM_DEPTH];

  logic           w_instr_in_range;
  logic           w_data_in_range;
  logic           w_ld_accept;
  logic           w_start;
  logic           w_cpu_we;
  logic           w_dmem_we;
  logic [DAW-1:0] w_dmem_addr;
  logic [15:0]    w_dmem_wdata;
  logic [16:0]    w_cnt_next;

  assign w_instr_in_range = {1'b0, bus.cpu_instr_addr} < IDEPTH;
  assign w_data_in_range  = {1'b0, bus.cpu_data_addr} < DDEPTH;
  assign w_ld_accept      = (r_state == S_LOAD) && bus.ld_valid && r_ld_ready;
  assign w_start          = bus.ld_start &&
                            ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERR));
  assign w_cpu_we         = (r_state == S_RUN) && bus.cpu_write && w_data_in_range;
  assign w_cnt_next       = r_ld_count + 17'd1;

`ifdef DMEM_CLEAR_EN
  logic [DAW-1:0] r_clr_cnt;

  // CLR walks dmem from the top address down; the CPU port is idle there.
  assign w_dmem_we    = w_cpu_we || (r_state == S_CLR);
  assign w_dmem_addr  = (r_state == S_CLR) ? r_clr_cnt : bus.cpu_data_addr[DAW-1:0];
  assign w_dmem_wdata = (r_state == S_CLR) ? 16'h0000 : bus.cpu_result;
`else
  assign w_dmem_we    = w_cpu_we;
  assign w_dmem_addr  = bus.cpu_data_addr[DAW-1:0];
  assign w_dmem_wdata = bus.cpu_result;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cpu_reset <= 1'b1;
      r_ld_ready  <= 1'b0;
      r_ld_error  <= 1'b0;
      r_ld_count  <= '0;
`ifdef DMEM_CLEAR_EN
      r_clr_cnt   <= '0;
`endif
    end else if (w_start) begin
      r_cpu_reset <= 1'b1;
      r_ld_error  <= 1'b0;
      r_ld_count  <= '0;
`ifdef DMEM_CLEAR_EN
      r_state     <= S_CLR;
      r_ld_ready  <= 1'b0;
      r_clr_cnt   <= DAW'(DMEM_DEPTH - 1);
`else
      r_state     <= S_LOAD;
      r_ld_ready  <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_ld_accept) begin
            r_ld_count <= w_cnt_next;
            if (bus.ld_last) begin
              r_state    <= S_CRST;
              r_ld_ready <= 1'b0;
            end else begin
              r_ld_ready <= w_cnt_next < IDEPTH;
            end
          end else if (bus.ld_valid && (r_ld_count == IDEPTH)) begin
            r_state    <= S_ERR;
            r_ld_error <= 1'b1;
            r_ld_ready <= 1'b0;
          end
        end
        S_CRST: begin
          r_state     <= S_RUN;
          r_cpu_reset <= 1'b0;
        end
`ifdef DMEM_CLEAR_EN
        S_CLR: begin
          if (r_clr_cnt == '0) begin
            r_state    <= S_LOAD;
            r_ld_ready <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt - 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Memories are deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_ld_accept) r_imem[r_ld_count[IAW-1:0]] <= bus.ld_data;
    if (w_dmem_we)   r_dmem[w_dmem_addr] <= w_dmem_wdata;
  end

  assign bus.cpu_instr = ((r_state == S_RUN) && w_instr_in_range) ?
                         r_imem[bus.cpu_instr_addr[IAW-1:0]] : 16'h0000;
  assign bus.cpu_data  = w_data_in_range ? r_dmem[bus.cpu_data_addr[DAW-1:0]] : 16'h0000;
  assign bus.cpu_reset = r_cpu_reset;
  assign bus.ld_ready  = r_ld_ready;
  assign bus.ld_error  = r_ld_error;
  assign bus.ld_count  = r_ld_count[15:0];

endmodule

// File: tb/tb_cpu_prog_mem.sv
// Self-checking bench for cpu_prog_mem: mode-level reference model with per-cycle compare,
// plus directed literal checks on a default instance and a 4-word-imem instance.
module tb_cpu_prog_mem;
  localparam int ID  = 256;
  localparam int DD  = 256;
  localparam int SID = 4;
  localparam int SDD = 16;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_CRST = 2;
  localparam int M_RUN  = 3;
  localparam int M_ERR  = 4;
  localparam int M_CLR  = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cpu_prog_mem_if bus();
  cpu_prog_mem_if sbus();

  cpu_prog_mem #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD)) u_dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  cpu_prog_mem #(.IMEM_DEPTH(SID), .DMEM_DEPTH(SDD)) u_small (
    .clk(clk), .reset(reset), .bus(sbus.slave)
  );

  int n_pass = 0;
  int n_tot  = 0;

  int          mode = M_IDLE;
  int          m_cnt = 0;
  int          clr_left = 0;
  logic [15:0] m_imem [ID];
  bit          m_ival [ID];
  logic [15:0] m_dmem [DD];
  bit          m_dval [DD];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Advance one clock; the model's effect of this edge is computed from the pre-edge inputs.
  task automatic cyc();
    int          nm = mode;
    int          nc = m_cnt;
    int          ncl = clr_left;
    bit          iwe = 0;
    bit          dwe = 0;
    int          ia = 0;
    int          da = 0;
    logic [15:0] iv = '0;
    logic [15:0] dv = '0;
    if (!reset) begin
      if (mode == M_RUN && bus.cpu_write && int'(bus.cpu_data_addr) < DD) begin
        dwe = 1; da = int'(bus.cpu_data_addr); dv = bus.cpu_result;
      end
      if ((mode == M_IDLE || mode == M_RUN || mode == M_ERR) && bus.ld_start) begin
        nc = 0;
`ifdef DMEM_CLEAR_EN
        nm = M_CLR; ncl = DD;
`else
        nm = M_LOAD;
`endif
      end else if (mode == M_LOAD) begin
        if (bus.ld_valid && m_cnt < ID) begin
          iwe = 1; ia = m_cnt; iv = bus.ld_data; nc = m_cnt + 1;
          if (bus.ld_last) nm = M_CRST;
        end else if (bus.ld_valid) begin
          nm = M_ERR;
        end
      end else if (mode == M_CRST) begin
        nm = M_RUN;
      end else if (mode == M_CLR) begin
        ncl = clr_left - 1;
        if (ncl == 0) nm = M_LOAD;
      end
    end
    @(posedge clk);
    if (nm == M_CLR && mode != M_CLR) foreach (m_dval[k]) m_dval[k] = 0;
    if (nm == M_LOAD && mode == M_CLR) foreach (m_dval[k]) begin m_dval[k] = 1; m_dmem[k] = 16'h0000; end
    mode = nm; m_cnt = nc; clr_left = ncl;
    if (iwe) begin m_imem[ia] = iv; m_ival[ia] = 1; end
    if (dwe) begin m_dmem[da] = dv; m_dval[da] = 1; end
    #1;
  endtask

  task automatic wait_load();
    int n = 0;
    while (mode != M_LOAD && n < 2000) begin cyc(); n++; end
    if (mode != M_LOAD) begin
      n_tot++;
      $display("FAIL wait_load: timed out after %0d cycles", n);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    bus.ld_valid = 1'b1; bus.ld_data = d; bus.ld_last = last;
    cyc();
  endtask

  always @(negedge clk) begin : cmp
    int a;
    chk("cpu_reset", 32'(bus.cpu_reset), 32'(mode != M_RUN));
    chk("ld_ready",  32'(bus.ld_ready),  32'(mode == M_LOAD && m_cnt < ID));
    chk("ld_error",  32'(bus.ld_error),  32'(mode == M_ERR));
    chk("ld_count",  32'(bus.ld_count),  32'(m_cnt));
    a = int'(bus.cpu_instr_addr);
    if (mode != M_RUN || a >= ID) chk("cpu_instr", 32'(bus.cpu_instr), 32'h0);
    else if (m_ival[a])           chk("cpu_instr", 32'(bus.cpu_instr), 32'(m_imem[a]));
    a = int'(bus.cpu_data_addr);
    if (a >= DD)        chk("cpu_data", 32'(bus.cpu_data), 32'h0);
    else if (m_dval[a]) chk("cpu_data", 32'(bus.cpu_data), 32'(m_dmem[a]));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.cpu_instr_addr = '0; bus.cpu_data_addr = '0; bus.cpu_result = '0; bus.cpu_write = 0;
    bus.ld_start = 0; bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
    sbus.cpu_instr_addr = '0; sbus.cpu_data_addr = '0; sbus.cpu_result = '0; sbus.cpu_write = 0;
    sbus.ld_start = 0; sbus.ld_valid = 0; sbus.ld_data = '0; sbus.ld_last = 0;
    #1 reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_ld_count", 32'(bus.ld_count), 32'h0);
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'h1);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'h0);

    // Program load and release
    bus.ld_start = 1; cyc(); bus.ld_start = 0;
    wait_load();
    send(16'h80FF, 0); send(16'h3C01, 0); send(16'h1000, 1);
    bus.ld_valid = 0; bus.ld_last = 0;
    chk("t1_count", 32'(bus.ld_count), 32'd3);
    chk("t1_crst_reset", 32'(bus.cpu_reset), 32'h1);
    cyc();
    chk("t1_run_reset", 32'(bus.cpu_reset), 32'h0);
    bus.cpu_instr_addr = 16'h0000; #1 chk("t1_instr0", 32'(bus.cpu_instr), 32'h80FF);
    bus.cpu_instr_addr = 16'h0001; #1 chk("t1_instr1", 32'(bus.cpu_instr), 32'h3C01);

    // Data write, no-write, read-during-write
    bus.cpu_data_addr = 16'h00FF; bus.cpu_result = 16'h0001; bus.cpu_write = 1;
    cyc(); bus.cpu_write = 0;
    #1 chk("t2_write", 32'(bus.cpu_data), 32'h0001);
    bus.cpu_result = 16'h5555; cyc();
    chk("t2_nowrite", 32'(bus.cpu_data), 32'h0001);
    bus.cpu_write = 1; bus.cpu_result = 16'h0002;
    #1 chk("t2_rdw_old", 32'(bus.cpu_data), 32'h0001);
    cyc(); bus.cpu_write = 0;
    #1 chk("t2_rdw_new", 32'(bus.cpu_data), 32'h0002);

    // Out-of-range fetch and write
    bus.cpu_instr_addr = 16'h1000; #1 chk("t5_instr_oob", 32'(bus.cpu_instr), 32'h0);
    bus.cpu_data_addr = 16'h0000; bus.cpu_result = 16'h1234; bus.cpu_write = 1; cyc();
    bus.cpu_data_addr = 16'h0100; bus.cpu_result = 16'hDEAD; cyc(); bus.cpu_write = 0;
    #1 chk("t5_data_oob", 32'(bus.cpu_data), 32'h0);
    bus.cpu_data_addr = 16'h0000; #1 chk("t5_dmem0", 32'(bus.cpu_data), 32'h1234);

    // dmem across a reload from RUN
    bus.cpu_data_addr = 16'h0005; bus.cpu_result = 16'hABCD; bus.cpu_write = 1; cyc();
    bus.cpu_write = 0;
    #1 chk("t6_pre", 32'(bus.cpu_data), 32'hABCD);
    bus.ld_start = 1; cyc(); bus.ld_start = 0;
`ifdef DMEM_CLEAR_EN
    n = 0;
    while (bus.ld_ready == 1'b0 && n < 1000) begin cyc(); n++; end
    chk("t6_clr_cycles", 32'(n), 32'd256);
`endif
    wait_load();
    send(16'h2222, 1); bus.ld_valid = 0; bus.ld_last = 0;
    cyc();
    bus.cpu_data_addr = 16'h0005; bus.cpu_instr_addr = 16'h0000;
`ifdef DMEM_CLEAR_EN
    #1 chk("t6_dmem5", 32'(bus.cpu_data), 32'h0000);
`else
    #1 chk("t6_dmem5", 32'(bus.cpu_data), 32'hABCD);
`endif
    chk("t6_instr0", 32'(bus.cpu_instr), 32'h2222);

    // Async reset mid-load, then shorter reload
    bus.ld_start = 1; cyc(); bus.ld_start = 0;
    wait_load();
    send(16'hAAAA, 0); send(16'hBBBB, 0); bus.ld_valid = 0;
    #1 reset = 1'b1; mode = M_IDLE; m_cnt = 0;
    #1 chk("t4_async_ready", 32'(bus.ld_ready), 32'h0);
    chk("t4_async_cpu_reset", 32'(bus.cpu_reset), 32'h1);
    chk("t4_async_count", 32'(bus.ld_count), 32'h0);
    cyc(); reset = 1'b0; cyc();
    bus.ld_start = 1; cyc(); bus.ld_start = 0;
    wait_load();
    send(16'h1111, 1); bus.ld_valid = 0; bus.ld_last = 0;
    cyc();
    bus.cpu_instr_addr = 16'h0000; #1 chk("t4_instr0", 32'(bus.cpu_instr), 32'h1111);
    bus.cpu_instr_addr = 16'h0001; #1 chk("t4_instr1", 32'(bus.cpu_instr), 32'hBBBB);
    bus.cpu_instr_addr = 16'h0002; #1 chk("t4_instr2", 32'(bus.cpu_instr), 32'h1000);

    // Overflow on the 4-word instance
    sbus.ld_start = 1; cyc(); sbus.ld_start = 0;
    n = 0;
    while (sbus.ld_ready == 1'b0 && n < 100) begin cyc(); n++; end
    chk("t3_ready_on", 32'(sbus.ld_ready), 32'h1);
    sbus.ld_valid = 1;
    for (int i = 0; i < 4; i++) begin sbus.ld_data = 16'(16'h10 + i); cyc(); end
    chk("t3_count_full", 32'(sbus.ld_count), 32'd4);
    chk("t3_ready_full", 32'(sbus.ld_ready), 32'h0);
    chk("t3_err_before", 32'(sbus.ld_error), 32'h0);
    cyc();
    chk("t3_err", 32'(sbus.ld_error), 32'h1);
    chk("t3_err_cpu_reset", 32'(sbus.cpu_reset), 32'h1);
    chk("t3_err_ready", 32'(sbus.ld_ready), 32'h0);
    sbus.ld_valid = 0; sbus.ld_start = 1; cyc(); sbus.ld_start = 0;
    chk("t3_err_clear", 32'(sbus.ld_error), 32'h0);
    chk("t3_count_clear", 32'(sbus.ld_count), 32'h0);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
